// File: rtl/dmux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmux_pkg
//  Purpose  : Shared types and constants for the 1-to-4 stream demultiplexer.
//  Contents : N_OUT          - number of output channels
//             DMUX_W_DEFAULT - default data word width
//             dmux_sel_t     - channel select type
//             slot_state_t   - per-channel slot state encoding
//  Revision : 1.0 - initial release
// ============================================================================
package dmux_pkg;

   localparam int N_OUT          = 4;
   localparam int DMUX_W_DEFAULT = 16;

   typedef logic [1:0] dmux_sel_t;

   typedef enum logic [0:0] {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

endpackage : dmux_pkg
`default_nettype wire

// File: rtl/dmux_slot.sv
`default_nettype none
// ============================================================================
//  Module   : dmux_slot
//  Purpose  : One-entry registered output slot with a valid/ready handshake.
//             A load while full is only legal in the same cycle the consumer
//             drains the held word, which gives back-to-back throughput.
//  Ports    : clk     - clock, rising edge
//             rst     - synchronous active-high reset, clears valid and data
//             load    - write ld_data into the slot this cycle
//             ld_data - word to store
//             ready   - consumer takes the held word this cycle
//             valid   - slot holds a word
//             data    - held word
//  Revision : 1.0 - initial release
// ============================================================================
module dmux_slot
   import dmux_pkg::*;
#(
   parameter int WIDTH = DMUX_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] ld_data,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   slot_state_t      state, state_nxt;
   logic [WIDTH-1:0] data_q, data_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= SLOT_EMPTY;
         data_q <= '0;
      end else begin
         state  <= state_nxt;
         data_q <= data_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      data_nxt  = data_q;
      case (state)
         SLOT_EMPTY: begin
            // ready is ignored while empty
            if (load) begin
               state_nxt = SLOT_FULL;
               data_nxt  = ld_data;
            end
         end
         SLOT_FULL: begin
            // Without ready the word is frozen; the upstream in_ready gate
            // guarantees no load arrives here in that case.
            if (ready) begin
               if (load) begin
                  data_nxt = ld_data;
               end else begin
                  state_nxt = SLOT_EMPTY;
               end
            end
         end
         default: state_nxt = SLOT_EMPTY;
      endcase
   end

   assign valid = (state == SLOT_FULL);
   assign data  = data_q;

endmodule : dmux_slot
`default_nettype wire

// File: rtl/dmux4way_stream_16bit.sv
`default_nettype none
// ============================================================================
//  Module   : dmux4way_stream_16bit
//  Purpose  : 1-to-4 stream demultiplexer. Each accepted input word is routed
//             to the output slot chosen by in_sel. A stalled channel only
//             blocks words addressed to itself.
//  Ports    : clk, rst             - clock / synchronous active-high reset
//             in_data, in_sel      - word and destination channel
//             in_valid, in_ready   - input handshake
//             out_data0..3         - per-channel data
//             out_valid, out_ready - per-channel handshake (bit k = channel k)
//             cnt0..3              - per-channel accepted-word counters
//  Config   : DMUX_STATS_EN - when defined, adds the cnt0..3 ports and
//             wrapping 16-bit accept counters.
//  Revision : 1.0 - initial release
// ============================================================================
module dmux4way_stream_16bit
   import dmux_pkg::*;
#(
   parameter int WIDTH = DMUX_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  dmux_sel_t        in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data0,
   output logic [WIDTH-1:0] out_data1,
   output logic [WIDTH-1:0] out_data2,
   output logic [WIDTH-1:0] out_data3,
   output logic [N_OUT-1:0] out_valid,
   input  logic [N_OUT-1:0] out_ready
`ifdef DMUX_STATS_EN
   ,
   output logic [15:0]      cnt0,
   output logic [15:0]      cnt1,
   output logic [15:0]      cnt2,
   output logic [15:0]      cnt3
`endif
);

   logic             accept;
   logic [N_OUT-1:0] load_vec;
   logic [WIDTH-1:0] slot_data [N_OUT];

   // The addressed slot can take a word if empty or draining this cycle;
   // this is the only combinational path from outputs back to inputs.
   assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
   assign accept   = in_valid & in_ready;

   always_comb begin
      load_vec = '0;
      if (accept) begin
         load_vec[in_sel] = 1'b1;
      end
   end

   generate
      for (genvar k = 0; k < N_OUT; k++) begin : g_slot
         dmux_slot #(
            .WIDTH (WIDTH)
         ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .load    (load_vec[k]),
            .ld_data (in_data),
            .ready   (out_ready[k]),
            .valid   (out_valid[k]),
            .data    (slot_data[k])
         );
      end
   endgenerate

   assign out_data0 = slot_data[0];
   assign out_data1 = slot_data[1];
   assign out_data2 = slot_data[2];
   assign out_data3 = slot_data[3];

`ifdef DMUX_STATS_EN
   logic [15:0] cnt_q [N_OUT];

   // Counters wrap naturally at 16 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < N_OUT; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < N_OUT; k++) begin
            if (load_vec[k]) begin
               cnt_q[k] <= cnt_q[k] + 16'd1;
            end
         end
      end
   end

   assign cnt0 = cnt_q[0];
   assign cnt1 = cnt_q[1];
   assign cnt2 = cnt_q[2];
   assign cnt3 = cnt_q[3];
`endif

endmodule : dmux4way_stream_16bit
`default_nettype wire

// File: tb/tb_dmux4way_stream_16bit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmux4way_stream_16bit
//  Purpose  : Self-checking bench for dmux4way_stream_16bit: directed vector
//             table, hand-written reset sequence, randomized traffic against
//             a per-channel queue model, and counter wrap when DMUX_STATS_EN
//             is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmux4way_stream_16bit;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_data;
   logic [1:0]  in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_data0, out_data1, out_data2, out_data3;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
`ifdef DMUX_STATS_EN
   logic [15:0] cnt0, cnt1, cnt2, cnt3;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dmux4way_stream_16bit dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data0 (out_data0),
      .out_data1 (out_data1),
      .out_data2 (out_data2),
      .out_data3 (out_data3),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef DMUX_STATS_EN
      ,
      .cnt0      (cnt0),
      .cnt1      (cnt1),
      .cnt2      (cnt2),
      .cnt3      (cnt3)
`endif
   );

   function automatic logic [15:0] odata(input int k);
      case (k)
         0:       return out_data0;
         1:       return out_data1;
         2:       return out_data2;
         default: return out_data3;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Directed vectors: inputs applied after the falling edge, expectations
   // are the outputs seen with those inputs before the next rising edge.
   typedef struct {
      logic        rst;
      logic        v;
      logic [1:0]  sel;
      logic [15:0] d;
      logic [3:0]  ordy;
      logic        chk;
      logic        exp_rdy;
      logic [3:0]  exp_v;
      logic        chk_d;
      logic [1:0]  dch;
      logic [15:0] exp_d;
   } vec_t;

   vec_t tbl [20];

   // Queue model: a channel holds at most one word.
   logic [15:0] q [4][$];
   logic [15:0] mcnt [4];

   initial begin
      rst = 1'b0; in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = '0;

      //             rst  v    sel  d        ordy     chk  rdy  exp_v    chkd dch  exp_d
      tbl[0]  = '{1'b1,1'b1,2'd0,16'hFFFF,4'b0000,1'b0,1'b0,4'b0000,1'b0,2'd0,16'h0000};
      tbl[1]  = '{1'b1,1'b1,2'd0,16'hFFFF,4'b0000,1'b1,1'b1,4'b0000,1'b1,2'd0,16'h0000};
      // single route to channel 2, hold, then drain
      tbl[2]  = '{1'b0,1'b1,2'd2,16'hA5A5,4'b0000,1'b1,1'b1,4'b0000,1'b1,2'd2,16'h0000};
      tbl[3]  = '{1'b0,1'b0,2'd0,16'h0000,4'b0000,1'b1,1'b1,4'b0100,1'b1,2'd2,16'hA5A5};
      tbl[4]  = '{1'b0,1'b0,2'd2,16'h0000,4'b0000,1'b1,1'b0,4'b0100,1'b1,2'd2,16'hA5A5};
      tbl[5]  = '{1'b0,1'b0,2'd2,16'h0000,4'b0100,1'b1,1'b1,4'b0100,1'b1,2'd2,16'hA5A5};
      tbl[6]  = '{1'b0,1'b0,2'd0,16'h0000,4'b0000,1'b1,1'b1,4'b0000,1'b0,2'd0,16'h0000};
      // backpressure isolation: channel 1 stalled, channel 3 still accepts
      tbl[7]  = '{1'b0,1'b1,2'd1,16'hBEEF,4'b0000,1'b1,1'b1,4'b0000,1'b0,2'd0,16'h0000};
      tbl[8]  = '{1'b0,1'b1,2'd1,16'hDEAD,4'b0000,1'b1,1'b0,4'b0010,1'b1,2'd1,16'hBEEF};
      tbl[9]  = '{1'b0,1'b1,2'd3,16'h1234,4'b0000,1'b1,1'b1,4'b0010,1'b1,2'd1,16'hBEEF};
      tbl[10] = '{1'b0,1'b0,2'd1,16'h0000,4'b0000,1'b1,1'b0,4'b1010,1'b1,2'd3,16'h1234};
      tbl[11] = '{1'b0,1'b0,2'd0,16'h0000,4'b0000,1'b1,1'b1,4'b1010,1'b1,2'd1,16'hBEEF};
      tbl[12] = '{1'b0,1'b0,2'd0,16'h0000,4'b1010,1'b1,1'b1,4'b1010,1'b1,2'd3,16'h1234};
      tbl[13] = '{1'b0,1'b0,2'd0,16'h0000,4'b0000,1'b1,1'b1,4'b0000,1'b0,2'd0,16'h0000};
      // full throughput on channel 0
      tbl[14] = '{1'b0,1'b1,2'd0,16'h0001,4'b1111,1'b1,1'b1,4'b0000,1'b0,2'd0,16'h0000};
      tbl[15] = '{1'b0,1'b1,2'd0,16'h0002,4'b1111,1'b1,1'b1,4'b0001,1'b1,2'd0,16'h0001};
      tbl[16] = '{1'b0,1'b1,2'd0,16'h0003,4'b1111,1'b1,1'b1,4'b0001,1'b1,2'd0,16'h0002};
      tbl[17] = '{1'b0,1'b1,2'd0,16'h0004,4'b1111,1'b1,1'b1,4'b0001,1'b1,2'd0,16'h0003};
      tbl[18] = '{1'b0,1'b0,2'd0,16'h0000,4'b1111,1'b1,1'b1,4'b0001,1'b1,2'd0,16'h0004};
      tbl[19] = '{1'b0,1'b0,2'd0,16'h0000,4'b0000,1'b1,1'b1,4'b0000,1'b0,2'd0,16'h0000};

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         rst = tbl[i].rst; in_valid = tbl[i].v; in_sel = tbl[i].sel;
         in_data = tbl[i].d; out_ready = tbl[i].ordy;
         #1;
         if (tbl[i].chk) begin
            check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].exp_v));
            if (tbl[i].chk_d)
               check($sformatf("vec%0d out_data%0d", i, tbl[i].dch),
                     32'(odata(int'(tbl[i].dch))), 32'(tbl[i].exp_d));
         end
         @(posedge clk);
      end

      // Reset mid-operation: fill all four slots, then reset; words are lost.
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         rst = 1'b0; in_valid = 1'b1; in_sel = 2'(k); in_data = 16'(16'h0100 + k); out_ready = '0;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1 check("all_full out_valid", 32'(out_valid), 32'hF);
      check("all_full out_data3", 32'(out_data3), 32'h0103);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; out_ready = 4'b1111;
      #1 check("rst_mid out_valid", 32'(out_valid), 32'h0);
      for (int k = 0; k < 4; k++)
         check($sformatf("rst_mid out_data%0d", k), 32'(odata(k)), 32'h0);
      check("rst_mid in_ready", 32'(in_ready), 32'h1);
      @(negedge clk);
      #1 check("post_rst out_valid", 32'(out_valid), 32'h0);

      // Randomized traffic against the queue model; starts from a reset.
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         q[k].delete();
         mcnt[k] = '0;
      end
      for (int c = 0; c < 600; c++) begin
         logic       r, exp_rdy;
         logic [3:0] mv;
         r         = ($urandom_range(0, 59) == 0);
         rst       = r;
         in_valid  = ($urandom_range(0, 3) != 0);
         in_sel    = 2'($urandom_range(0, 3));
         in_data   = 16'($urandom);
         out_ready = 4'($urandom);
         #1;
         for (int k = 0; k < 4; k++) mv[k] = (q[k].size() != 0);
         exp_rdy = !mv[in_sel] || out_ready[in_sel];
         check("rnd in_ready", 32'(in_ready), 32'(exp_rdy));
         check("rnd out_valid", 32'(out_valid), 32'(mv));
         for (int k = 0; k < 4; k++)
            if (mv[k]) check($sformatf("rnd out_data%0d", k), 32'(odata(k)), 32'(q[k][0]));
`ifdef DMUX_STATS_EN
         check("rnd cnt0", 32'(cnt0), 32'(mcnt[0]));
         check("rnd cnt3", 32'(cnt3), 32'(mcnt[3]));
`endif
         if (r) begin
            for (int k = 0; k < 4; k++) begin
               q[k].delete();
               mcnt[k] = '0;
            end
         end else begin
            for (int k = 0; k < 4; k++)
               if (mv[k] && out_ready[k]) void'(q[k].pop_front());
            if (in_valid && exp_rdy) begin
               q[in_sel].push_back(in_data);
               mcnt[in_sel] = mcnt[in_sel] + 16'd1;
            end
         end
         @(negedge clk);
      end

`ifdef DMUX_STATS_EN
      // 65537 accepts on channel 0 wrap its counter to 1.
      rst = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b1; in_sel = 2'd0; out_ready = 4'b1111;
      for (int c = 0; c < 65537; c++) @(negedge clk);
      in_valid = 1'b0;
      #1 check("wrap cnt0", 32'(cnt0), 32'h1);
      check("wrap cnt1", 32'(cnt1), 32'h0);
      check("wrap cnt2", 32'(cnt2), 32'h0);
      check("wrap cnt3", 32'(cnt3), 32'h0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1 check("rst cnt0", 32'(cnt0), 32'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_dmux4way_stream_16bit
`default_nettype wire
